// File: rtl/row_normalizer_pkg.sv
// Shared fixed-point widths for the FlashAttention output normalisation path.
// Divider inputs are signed Q8.8; divider quotients are signed Q0.7.
package row_normalizer_pkg;

   localparam int DIV_INPUT_W       = 16;
   localparam int DIV_INPUT_FRAC    = 8;
   localparam int QUOT_W            = 8;
   localparam int QUOT_FRAC         = 7;
   localparam int NORM_ROW_LEN      = 16;
   localparam int DEF_MAX_INFLIGHT  = 4;

endpackage

// File: rtl/row_normalizer.sv
// Divides one accumulated output row by its row sum through an external int_division
// block, keeping up to MAX_INFLIGHT divides outstanding, and hands the row downstream.
module row_normalizer
   import row_normalizer_pkg::*;
#(
   parameter int NUM_ELEMS    = NORM_ROW_LEN,
   parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             vld_in,
   output logic                             rdy_out,
   input  logic [NUM_ELEMS*DIV_INPUT_W-1:0] row_in,
   input  logic [DIV_INPUT_W-1:0]           row_sum_in,
   output logic                             div_vld_out,
   input  logic                             div_rdy_in,
   output logic [DIV_INPUT_W-1:0]           div_numerator_out,
   output logic [DIV_INPUT_W-1:0]           div_denominator_out,
   input  logic                             div_vld_in,
   output logic                             div_rdy_out,
   input  logic [QUOT_W-1:0]                div_quotient_in,
   output logic                             vld_out,
   input  logic                             rdy_in,
   output logic [NUM_ELEMS*QUOT_W-1:0]      row_out
);

   localparam int IDX_W = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
   localparam int CNT_W = IDX_W + 1;
   localparam int INF_W = $clog2(MAX_INFLIGHT + 1);
   localparam logic [CNT_W-1:0] ROW_LEN  = CNT_W'(NUM_ELEMS);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ELEMS - 1);
   localparam logic [INF_W-1:0] INF_MAX  = INF_W'(MAX_INFLIGHT);

   typedef enum logic [1:0] {IDLE, RUN, OUT} norm_state_t;

   norm_state_t state, state_next;

   logic [CNT_W-1:0]                         issue_idx;
   logic [CNT_W-1:0]                         recv_idx;
   logic [INF_W-1:0]                         inflight;
   logic [NUM_ELEMS-1:0][DIV_INPUT_W-1:0]    row_reg;
   logic [DIV_INPUT_W-1:0]                   sum_reg;
   logic [NUM_ELEMS-1:0][QUOT_W-1:0]         quot_reg;

   logic accept;
   logic issue;
   logic receive;
   logic release_row;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Issue and collect are independent inside RUN; quotients come back in issue order,
   // so recv_idx alone places each one. Returns past the end of the row are dropped.
   always_comb begin
      state_next  = state;
      rdy_out     = 1'b0;
      div_vld_out = 1'b0;
      div_rdy_out = 1'b0;
      vld_out     = 1'b0;
      accept      = 1'b0;
      issue       = 1'b0;
      receive     = 1'b0;
      release_row = 1'b0;
      case (state)
         IDLE: begin
            rdy_out = 1'b1;
            accept  = vld_in;
            if (vld_in) begin
               state_next = RUN;
            end
         end
         RUN: begin
            div_rdy_out = 1'b1;
            div_vld_out = (issue_idx < ROW_LEN) && (inflight < INF_MAX);
            issue       = div_vld_out && div_rdy_in;
            receive     = div_vld_in && (recv_idx < ROW_LEN);
            if (receive && (recv_idx == LAST_IDX)) begin
               state_next = OUT;
            end
         end
         OUT: begin
            vld_out     = 1'b1;
            release_row = rdy_in;
            if (rdy_in) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign div_numerator_out   = row_reg[issue_idx[IDX_W-1:0]];
   assign div_denominator_out = sum_reg;
   assign row_out             = quot_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         issue_idx <= '0;
         recv_idx  <= '0;
         inflight  <= '0;
         row_reg   <= '0;
         sum_reg   <= '0;
         quot_reg  <= '0;
      end else begin
         if (accept) begin
            row_reg <= row_in;
            sum_reg <= row_sum_in;
         end
         if (issue) begin
            issue_idx <= issue_idx + 1'b1;
         end
         if (receive) begin
            quot_reg[recv_idx[IDX_W-1:0]] <= div_quotient_in;
            recv_idx                      <= recv_idx + 1'b1;
         end
         case ({issue, receive})
            2'b10:   inflight <= inflight + 1'b1;
            2'b01:   inflight <= inflight - 1'b1;
            default: inflight <= inflight;
         endcase
         if (release_row) begin
            issue_idx <= '0;
            recv_idx  <= '0;
         end
      end
   end

   // A quotient is only legal while a row is still collecting.
   assert property (@(posedge clk) disable iff (rst)
      div_vld_in |-> ((state == RUN) && (recv_idx < ROW_LEN)));

endmodule

// File: tb/tb_row_normalizer.sv
// Randomised scoreboard bench for row_normalizer with a variable-latency divider model.
// Expected rows come from real-valued division of the row by its sum.
module tb_row_normalizer;
   import row_normalizer_pkg::*;

   localparam int N    = 16;
   localparam int MAXI = 4;
   localparam int DW   = DIV_INPUT_W;
   localparam int QW   = QUOT_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              vld_in = 1'b0;
   logic              rdy_out;
   logic [N*DW-1:0]   row_in = '0;
   logic [DW-1:0]     row_sum_in = '0;
   logic              div_vld_out;
   logic              div_rdy_in = 1'b1;
   logic [DW-1:0]     div_numerator_out;
   logic [DW-1:0]     div_denominator_out;
   logic              div_vld_in = 1'b0;
   logic              div_rdy_out;
   logic [QW-1:0]     div_quotient_in = '0;
   logic              vld_out;
   logic              rdy_in = 1'b1;
   logic [N*QW-1:0]   row_out;

   row_normalizer #(.NUM_ELEMS(N), .MAX_INFLIGHT(MAXI)) dut (
      .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_out(rdy_out),
      .row_in(row_in), .row_sum_in(row_sum_in),
      .div_vld_out(div_vld_out), .div_rdy_in(div_rdy_in),
      .div_numerator_out(div_numerator_out), .div_denominator_out(div_denominator_out),
      .div_vld_in(div_vld_in), .div_rdy_out(div_rdy_out), .div_quotient_in(div_quotient_in),
      .vld_out(vld_out), .rdy_in(rdy_in), .row_out(row_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int fails  = 0;

   logic [N*QW-1:0] exp_q[$];
   int              acc_q[$];
   int              rows_pushed = 0;
   int              rows_done   = 0;

   int  rdy_mode = 0;
   bit  div_rdy_rand = 0;
   int  lat_min = 1;
   int  lat_max = 1;

   typedef struct {
      logic signed [DW-1:0] num;
      logic signed [DW-1:0] den;
      int                   ready_at;
   } div_item_t;
   div_item_t dq[$];
   int        outstanding = 0;
   int        recv_count  = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Q8.8 / Q8.8 scaled to Q0.7, rounded half away from zero, saturated.
   function automatic logic [QW-1:0] ref_quot(input logic signed [DW-1:0] num,
                                              input logic signed [DW-1:0] den);
      real r;
      int  q;
      if (den == 0) return (num >= 0) ? 8'h7F : 8'h80;
      r = (real'(num) * 128.0) / real'(den);
      if (r >= 0.0) q = $rtoi(r + 0.5);
      else          q = -$rtoi(-r + 0.5);
      if (q > 127)  q = 127;
      if (q < -128) q = -128;
      return QW'(q);
   endfunction

   function automatic logic [N*QW-1:0] model_row(input logic [N*DW-1:0] r,
                                                 input logic signed [DW-1:0] l);
      logic [N*QW-1:0] e;
      for (int i = 0; i < N; i++) e[i*QW +: QW] = ref_quot(r[i*DW +: DW], l);
      return e;
   endfunction

   // Downstream ready driver.
   always @(negedge clk) begin
      case (rdy_mode)
         0:       rdy_in = 1'b1;
         1:       rdy_in = 1'b0;
         default: rdy_in = ($urandom_range(0, 1) == 1);
      endcase
   end

   // Divider substitute: in-order pipeline with random latency and random input stalls.
   always @(negedge clk) begin
      div_rdy_in = div_rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (dq.size() > 0 && dq[0].ready_at <= cyc + 1) begin
         div_vld_in      = 1'b1;
         div_quotient_in = ref_quot(dq[0].num, dq[0].den);
      end else begin
         div_vld_in      = 1'b0;
         div_quotient_in = QW'($urandom);
      end
      #1;
      if (rst) begin
         dq.delete();
         outstanding = 0;
      end else begin
         if (div_vld_in && div_rdy_out) begin
            void'(dq.pop_front());
            outstanding--;
            recv_count++;
         end
         if (div_vld_out && div_rdy_in) begin
            dq.push_back('{div_numerator_out, div_denominator_out,
                           cyc + 1 + $urandom_range(lat_min, lat_max)});
            outstanding++;
            checks++;
            if (outstanding > MAXI) begin
               fails++;
               $display("[TB] FAIL inflight_bound: got %0d allowed %0d", outstanding, MAXI);
            end
         end
      end
   end

   // Monitor: pops the scoreboard on every downstream transfer.
   always @(negedge clk) begin
      #2;
      if (!rst && vld_out && rdy_in) begin
         if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL unexpected_row: got %0h with nothing expected", row_out);
         end else begin
            logic [N*QW-1:0] e;
            int              a;
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            check("row_out", row_out, e);
            checks++;
            if (cyc - a < N + 2) begin
               fails++;
               $display("[TB] FAIL row_latency: got %0d cycles required >= %0d", cyc - a, N + 2);
            end
         end
         rows_done++;
      end
   end

   task automatic push_expect(input logic [N*QW-1:0] e);
      exp_q.push_back(e);
      acc_q.push_back(cyc);
      rows_pushed++;
   endtask

   task automatic applyStimulus(input logic [N*DW-1:0] r, input logic [DW-1:0] l,
                                input logic [N*QW-1:0] e);
      bit done = 0;
      @(negedge clk);
      vld_in     = 1'b1;
      row_in     = r;
      row_sum_in = l;
      for (int t = 0; t < 3000 && !done; t++) begin
         #1;
         if (rdy_out) begin
            push_expect(e);
            done = 1;
         end
         @(negedge clk);
      end
      vld_in = 1'b0;
      check("accept_timeout", 128'(done), 128'd1);
   endtask

   task automatic checkOutput();
      bit done = 0;
      for (int t = 0; t < 5000 && !done; t++) begin
         @(negedge clk);
         #3;
         if (rows_done >= rows_pushed) done = 1;
      end
      check("rows_complete_timeout", 128'(done), 128'd1);
   endtask

   task automatic rand_row(output logic [N*DW-1:0] r, output logic [DW-1:0] l);
      for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'(int'($urandom_range(0, 1023)) - 512);
      if ($urandom_range(0, 7) == 0) l = '0;
      else begin
         l = DW'($urandom_range(64, 2048));
         if ($urandom_range(0, 3) == 0) l = -l;
      end
   endtask

   initial begin
      logic [N*DW-1:0] r, rb;
      logic [DW-1:0]   l, lb;
      logic [N*QW-1:0] e, eb;
      bit              seen;
      int              base;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_rdy_out", 128'(rdy_out), 128'd1);
      check("reset_vld_out", 128'(vld_out), 128'd0);
      check("reset_div_vld_out", 128'(div_vld_out), 128'd0);
      check("reset_div_rdy_out", 128'(div_rdy_out), 128'd0);
      check("reset_row_out", 128'(row_out), 128'd0);

      // Row [0.5,1.0,0.25,0,...] over l=2.0
      r = '0; e = '0;
      r[0*DW +: DW] = 16'sd128; r[1*DW +: DW] = 16'sd256; r[2*DW +: DW] = 16'sd64;
      e[0*QW +: QW] = 8'sd32;   e[1*QW +: QW] = 8'sd64;   e[2*QW +: QW] = 8'sd16;
      applyStimulus(r, 16'sd512, e);
      checkOutput();

      // Alternating -1.0/+1.0 over l=4.0
      for (int i = 0; i < N; i++) begin
         r[i*DW +: DW] = (i % 2 == 0) ? -16'sd256 : 16'sd256;
         e[i*QW +: QW] = (i % 2 == 0) ? -8'sd32 : 8'sd32;
      end
      applyStimulus(r, 16'sd1024, e);
      checkOutput();

      // l = 0 saturates by numerator sign
      for (int i = 0; i < N; i++) begin
         r[i*DW +: DW] = (i % 2 == 0) ? 16'sd128 : -16'sd128;
         e[i*QW +: QW] = (i % 2 == 0) ? 8'sd127 : -8'sd128;
      end
      applyStimulus(r, 16'sd0, e);
      checkOutput();

      // Stalling divider and random downstream backpressure
      div_rdy_rand = 1;
      rdy_mode     = 2;
      for (int k = 0; k < 12; k++) begin
         lat_min = (k < 6) ? 3 : 1;
         lat_max = (k < 6) ? 3 : 8;
         rand_row(r, l);
         applyStimulus(r, l, model_row(r, l));
      end
      checkOutput();
      div_rdy_rand = 0;
      lat_min = 1;
      lat_max = 2;

      // Hold downstream off for 20 cycles in OUT while a second row is offered
      rdy_mode = 1;
      rand_row(r, l);
      e = model_row(r, l);
      applyStimulus(r, l, e);
      seen = 0;
      for (int t = 0; t < 500 && !seen; t++) begin
         @(negedge clk);
         #1;
         if (vld_out) seen = 1;
      end
      check("hold_reach_out", 128'(seen), 128'd1);
      rand_row(rb, lb);
      eb = model_row(rb, lb);
      row_in = rb; row_sum_in = lb; vld_in = 1'b1;
      for (int k = 0; k < 20; k++) begin
         check("hold_vld_out", 128'(vld_out), 128'd1);
         check("hold_rdy_out", 128'(rdy_out), 128'd0);
         check("hold_row_out", 128'(row_out), 128'(e));
         @(negedge clk);
         #1;
      end
      rdy_mode = 0;
      seen = 0;
      for (int t = 0; t < 10 && !seen; t++) begin
         @(negedge clk);
         #1;
         if (rdy_in) seen = 1;
      end
      @(negedge clk);
      #1;
      check("second_row_rdy_out", 128'(rdy_out), 128'd1);
      if (rdy_out) push_expect(eb);
      @(negedge clk);
      vld_in = 1'b0;
      checkOutput();

      // Reset mid-row after five quotients, then a fresh row
      lat_min = 3;
      lat_max = 3;
      rand_row(r, l);
      base = recv_count;
      applyStimulus(r, l, model_row(r, l));
      seen = 0;
      for (int t = 0; t < 500 && !seen; t++) begin
         @(negedge clk);
         #2;
         if (recv_count - base >= 5) seen = 1;
      end
      check("abort_reach_recv5", 128'(seen), 128'd1);
      @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      acc_q.delete();
      rows_pushed = rows_done;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_rdy_out", 128'(rdy_out), 128'd1);
      check("abort_vld_out", 128'(vld_out), 128'd0);
      check("abort_div_vld_out", 128'(div_vld_out), 128'd0);
      check("abort_row_out", 128'(row_out), 128'd0);
      rand_row(r, l);
      applyStimulus(r, l, model_row(r, l));
      checkOutput();

      repeat (5) @(negedge clk);
      check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
